// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants, FSM encoding and branch-metric helper for the K=3 rate-1/2 Viterbi ACS stage
package viterbi_pkg;
    localparam int K      = 3;
    localparam int NUM_ST = 4;
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G0 = 3'b101;
    typedef enum logic [1:0] {ST_IDLE, ST_ACS, ST_SEL, ST_TRBK} acs_st_e;
    // Hamming distance between the received symbol and the encoder output
    // produced by input bit u leaving predecessor state pred = {m1,m0}.
    function automatic logic [1:0] branch_metric(input logic [1:0] code, input logic u, input logic [1:0] pred);
        logic [K-1:0] sr;
        logic [1:0] diff;
        sr   = {u, pred};
        diff = code ^ {^(sr & G1), ^(sr & G0)};
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction
endpackage

// File: rtl/viterbi_surv_mem.sv
// viterbi_surv_mem: survivor decision store, one 4-bit column per symbol
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address (symbol index)
//   wdata_i  : decision column, bit s = decision for target state s
//   raddr_i  : combinational read address
//   rdata_o  : column at raddr_i
module viterbi_surv_mem
    import viterbi_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [NUM_ST-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [NUM_ST-1:0] rdata_o
);
    logic [NUM_ST-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/viterbi_acs.sv
// viterbi_acs: add-compare-select, survivor storage and end-node selection feeding the traceback stage
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : frame start pulse (IDLE only)
//   i_valid, i_code : received hard-decision symbol {c1,c0}, o_ready handshake
//   i_trbk_done     : traceback finished, returns to IDLE
//   o_en_trbk       : traceback enable, high in TRBK
//   o_slt_node      : best end state chosen in SEL
//   o_prev_st_*     : per-state predecessor decoded from the replayed column
//   o_busy          : high outside IDLE
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int PM_W      = 6,
    parameter int PM_INIT   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_valid,
    input  logic [1:0] i_code,
    output logic       o_ready,
    input  logic       i_trbk_done,
    output logic       o_en_trbk,
    output logic [1:0] o_slt_node,
    output logic [1:0] o_prev_st_00,
    output logic [1:0] o_prev_st_10,
    output logic [1:0] o_prev_st_01,
    output logic [1:0] o_prev_st_11,
    output logic       o_busy
);
    localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [AW-1:0]   LAST   = AW'(FRAME_LEN - 1);
    localparam logic [PM_W-1:0] PM_MAX = '1;
    localparam logic [PM_W-1:0] PM_I   = PM_W'(PM_INIT);

    acs_st_e           st_q, st_d;
    logic [PM_W-1:0]   pm_q [NUM_ST];
    logic [PM_W-1:0]   pm_d [NUM_ST];
    logic [PM_W-1:0]   acs_pm [NUM_ST];
    logic [AW-1:0]     cnt_q, cnt_d, rptr_q, rptr_d;
    logic [1:0]        slt_q, slt_d, best;
    logic [NUM_ST-1:0] dec, rcol;
    logic              accept;

    assign accept = (st_q == ST_ACS) && i_valid;

    // Target {u,m1} is reached from {m1,0} and {m1,1}; decision = chosen m0,
    // ties go to m0=0 because only a strictly smaller m0=1 candidate wins.
    for (genvar t = 0; t < NUM_ST; t++) begin : g_bfly
        localparam logic [1:0] TGT = 2'(t);
        localparam logic [1:0] P0  = {TGT[0], 1'b0};
        localparam logic [1:0] P1  = {TGT[0], 1'b1};
        logic [PM_W:0]   sum0, sum1;
        logic [PM_W-1:0] c0, c1;
        assign sum0 = {1'b0, pm_q[P0]} + {{(PM_W-1){1'b0}}, branch_metric(i_code, TGT[1], P0)};
        assign sum1 = {1'b0, pm_q[P1]} + {{(PM_W-1){1'b0}}, branch_metric(i_code, TGT[1], P1)};
        assign c0 = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
        assign c1 = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];
        assign dec[t]    = c1 < c0;
        assign acs_pm[t] = dec[t] ? c1 : c0;
    end

    // Strict compare keeps the lowest-numbered state on ties.
    always_comb begin
        best = S00;
        for (int s = 1; s < NUM_ST; s++) best = (pm_q[s] < pm_q[best]) ? 2'(s) : best;
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        rptr_d = rptr_q;
        slt_d  = slt_q;
        pm_d   = pm_q;
        case (st_q)
            ST_IDLE: begin
                for (int s = 0; s < NUM_ST; s++) pm_d[s] = (s == 0) ? '0 : PM_I;
                cnt_d = '0;
                st_d  = i_start ? ST_ACS : ST_IDLE;
            end
            ST_ACS: begin
                if (i_valid) begin
                    pm_d  = acs_pm;
                    cnt_d = cnt_q + 1'b1;
                    st_d  = (cnt_q == LAST) ? ST_SEL : ST_ACS;
                end
            end
            ST_SEL: begin
                slt_d  = best;
                rptr_d = LAST;
                st_d   = ST_TRBK;
            end
            ST_TRBK: begin
                rptr_d = (rptr_q == '0) ? '0 : rptr_q - 1'b1;
                st_d   = i_trbk_done ? ST_IDLE : ST_TRBK;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            rptr_q <= '0;
            slt_q  <= S00;
            for (int s = 0; s < NUM_ST; s++) pm_q[s] <= (s == 0) ? '0 : PM_I;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            rptr_q <= rptr_d;
            slt_q  <= slt_d;
            pm_q   <= pm_d;
        end
    end

    viterbi_surv_mem #(.DEPTH(FRAME_LEN), .AW(AW)) u_mem (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (cnt_q),
        .wdata_i (dec),
        .raddr_i (rptr_q),
        .rdata_o (rcol)
    );

    assign o_ready    = st_q == ST_ACS;
    assign o_busy     = st_q != ST_IDLE;
    assign o_en_trbk  = st_q == ST_TRBK;
    assign o_slt_node = slt_q;
    // Predecessor of {a,b} is {b, decision}.
    assign o_prev_st_00 = o_en_trbk ? {S00[0], rcol[S00]} : 2'b00;
    assign o_prev_st_10 = o_en_trbk ? {S10[0], rcol[S10]} : 2'b00;
    assign o_prev_st_01 = o_en_trbk ? {S01[0], rcol[S01]} : 2'b00;
    assign o_prev_st_11 = o_en_trbk ? {S11[0], rcol[S11]} : 2'b00;
endmodule

// File: tb/tb_viterbi_acs.sv
// tb_viterbi_acs: randomized and directed checks of viterbi_acs against a trellis reference model
module tb_viterbi_acs;
    localparam int FL = 8;

    logic       clk = 1'b0;
    logic       rst, i_start, i_valid, i_trbk_done;
    logic [1:0] i_code;
    logic       o_ready, o_en_trbk, o_busy;
    logic [1:0] o_slt_node, o_prev_st_00, o_prev_st_10, o_prev_st_01, o_prev_st_11;

    viterbi_acs #(.FRAME_LEN(FL), .PM_W(6), .PM_INIT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_valid      (i_valid),
        .i_code       (i_code),
        .o_ready      (o_ready),
        .i_trbk_done  (i_trbk_done),
        .o_en_trbk    (o_en_trbk),
        .o_slt_node   (o_slt_node),
        .o_prev_st_00 (o_prev_st_00),
        .o_prev_st_10 (o_prev_st_10),
        .o_prev_st_01 (o_prev_st_01),
        .o_prev_st_11 (o_prev_st_11),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0] codes   [FL];
    logic [3:0] exp_dec [FL];
    logic [1:0] exp_slt;
    int         exp_min;
    logic [7:0] obs_prev [FL+2];
    logic [1:0] obs_slt  [FL+2];
    int         obs_lat;
    logic       obs_gap_rdy, obs_busy_start, obs_en_rep, obs_en_after, obs_busy_after;

    // Trellis reference: state value = 2*m1 + m0, next state = 2*u + m1.
    function automatic void model();
        int pm [4];
        int nx [4];
        int u, m1, p, bm, cand [2];
        pm = '{0, 15, 15, 15};
        for (int k = 0; k < FL; k++) begin
            for (int t = 0; t < 4; t++) begin
                u  = t / 2;
                m1 = t % 2;
                for (int b = 0; b < 2; b++) begin
                    p  = 2 * m1 + b;
                    bm = (int'(codes[k][1]) != (u ^ m1 ^ b) ? 1 : 0) + (int'(codes[k][0]) != (u ^ b) ? 1 : 0);
                    cand[b] = (pm[p] + bm > 63) ? 63 : pm[p] + bm;
                end
                exp_dec[k][t] = cand[1] < cand[0];
                nx[t] = exp_dec[k][t] ? cand[1] : cand[0];
            end
            pm = nx;
        end
        exp_slt = 2'd0;
        exp_min = pm[0];
        for (int s = 1; s < 4; s++) if (pm[s] < exp_min) begin
            exp_min = pm[s];
            exp_slt = 2'(s);
        end
    endfunction

    // Expected {p11,p10,p01,p00} on the j-th TRBK cycle (pointer FL-1-j, held at 0).
    function automatic logic [7:0] exp_prev(input int j);
        logic [3:0] col;
        logic [7:0] e;
        col = exp_dec[(j < FL) ? FL - 1 - j : 0];
        for (int t = 0; t < 4; t++) begin
            e[2*t+1] = 1'(t % 2);
            e[2*t]   = col[t];
        end
        return e;
    endfunction

    task automatic run_frame(input int gap_at, input int gap_len);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        obs_busy_start = o_busy;
        obs_gap_rdy = 1'b1;
        for (int k = 0; k < FL; k++) begin
            if (k == gap_at) repeat (gap_len) begin
                i_valid = 1'b0;
                i_start = 1'b1;
                i_code  = 2'($urandom);
                @(negedge clk);
                obs_gap_rdy &= o_ready;
            end
            i_start = 1'b0;
            i_valid = 1'b1;
            i_code  = codes[k];
            @(negedge clk);
        end
        i_valid = 1'b0;
        obs_lat = 1;
        while (!o_en_trbk && obs_lat < 10) begin
            @(negedge clk);
            obs_lat++;
        end
        obs_en_rep = 1'b1;
        for (int j = 0; j < FL + 2; j++) begin
            obs_prev[j] = {o_prev_st_11, o_prev_st_10, o_prev_st_01, o_prev_st_00};
            obs_slt[j]  = o_slt_node;
            obs_en_rep &= o_en_trbk;
            if (j < FL + 1) @(negedge clk);
        end
        i_trbk_done = 1'b1;
        @(negedge clk);
        i_trbk_done = 1'b0;
        obs_en_after   = o_en_trbk;
        obs_busy_after = o_busy;
    endtask

    task automatic load_codeword();
        codes = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (o_en_trbk !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", o_en_trbk); end
        if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_ready); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        if (o_slt_node !== 2'b00) begin errors++; $display("FAIL reset_slt got %b want 00", o_slt_node); end
        if ({o_prev_st_11, o_prev_st_10, o_prev_st_01, o_prev_st_00} !== 8'h00) begin
            errors++;
            $display("FAIL reset_prev got %h want 00", {o_prev_st_11, o_prev_st_10, o_prev_st_01, o_prev_st_00});
        end
        rst = 1'b0;
        i_start = 1'b0;
        i_valid = 1'b1;
        i_trbk_done = 1'b1;
        @(negedge clk);
        checks += 2;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL idle_ignore_ready got %b want 0", o_ready); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_ignore_busy got %b want 0", o_busy); end
        i_valid = 1'b0;
        i_trbk_done = 1'b0;
    endtask

    task automatic test_zero_frame();
        codes = '{default: 2'b00};
        model();
        run_frame(-1, 0);
        checks += 5;
        if (obs_slt[0] !== 2'b00) begin errors++; $display("FAIL zero_slt got %b want 00", obs_slt[0]); end
        if (obs_prev[0][1:0] !== 2'b00) begin errors++; $display("FAIL zero_prev00 got %b want 00", obs_prev[0][1:0]); end
        if (obs_prev[0][5:4] !== 2'b00) begin errors++; $display("FAIL zero_prev10 got %b want 00", obs_prev[0][5:4]); end
        if (obs_lat !== 2) begin errors++; $display("FAIL zero_latency got %0d want 2", obs_lat); end
        if (obs_en_rep !== 1'b1) begin errors++; $display("FAIL zero_en_hold got %b want 1", obs_en_rep); end
    endtask

    task automatic test_codeword();
        load_codeword();
        model();
        run_frame(-1, 0);
        checks++;
        if (obs_slt[0] !== 2'b00) begin errors++; $display("FAIL cw_slt got %b want 00", obs_slt[0]); end
        for (int j = 0; j < FL + 2; j++) begin
            checks += 2;
            if (obs_prev[j] !== exp_prev(j)) begin errors++; $display("FAIL cw_prev[%0d] got %h want %h", j, obs_prev[j], exp_prev(j)); end
            if (obs_slt[j] !== exp_slt) begin errors++; $display("FAIL cw_slt_hold[%0d] got %b want %b", j, obs_slt[j], exp_slt); end
        end
    endtask

    task automatic test_flip();
        load_codeword();
        codes[2] = 2'b10;
        model();
        run_frame(-1, 0);
        checks++;
        if (obs_slt[0] !== exp_slt) begin errors++; $display("FAIL flip_slt got %b want %b", obs_slt[0], exp_slt); end
        for (int j = 0; j < FL + 2; j++) begin
            checks++;
            if (obs_prev[j] !== exp_prev(j)) begin errors++; $display("FAIL flip_prev[%0d] got %h want %h", j, obs_prev[j], exp_prev(j)); end
        end
    endtask

    task automatic test_gaps();
        load_codeword();
        model();
        run_frame(4, 3);
        checks += 2;
        if (obs_gap_rdy !== 1'b1) begin errors++; $display("FAIL gap_ready got %b want 1", obs_gap_rdy); end
        if (obs_slt[0] !== exp_slt) begin errors++; $display("FAIL gap_slt got %b want %b", obs_slt[0], exp_slt); end
        for (int j = 0; j < FL + 2; j++) begin
            checks++;
            if (obs_prev[j] !== exp_prev(j)) begin errors++; $display("FAIL gap_prev[%0d] got %h want %h", j, obs_prev[j], exp_prev(j)); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1;
            i_code  = 2'($urandom);
            @(negedge clk);
        end
        i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (o_en_trbk !== 1'b0) begin errors++; $display("FAIL midrst_en got %b want 0", o_en_trbk); end
        if (o_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", o_ready); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", o_busy); end
        rst = 1'b0;
        load_codeword();
        model();
        run_frame(-1, 0);
        checks++;
        if (obs_slt[0] !== exp_slt) begin errors++; $display("FAIL midrst_slt got %b want %b", obs_slt[0], exp_slt); end
        for (int j = 0; j < FL + 2; j++) begin
            checks++;
            if (obs_prev[j] !== exp_prev(j)) begin errors++; $display("FAIL midrst_prev[%0d] got %h want %h", j, obs_prev[j], exp_prev(j)); end
        end
    endtask

    task automatic test_done_restart();
        load_codeword();
        model();
        run_frame(-1, 0);
        checks += 2;
        if (obs_en_after !== 1'b0) begin errors++; $display("FAIL done_en got %b want 0", obs_en_after); end
        if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL done_busy got %b want 0", obs_busy_after); end
        for (int k = 0; k < FL; k++) codes[k] = 2'($urandom);
        model();
        run_frame(-1, 0);
        checks += 2;
        if (obs_busy_start !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", obs_busy_start); end
        if (obs_slt[0] !== exp_slt) begin errors++; $display("FAIL restart_slt got %b want %b", obs_slt[0], exp_slt); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < FL; k++) codes[k] = 2'($urandom);
            model();
            run_frame($urandom_range(0, FL - 1), $urandom_range(0, 3));
            checks += 2;
            if (obs_slt[0] !== exp_slt) begin errors++; $display("FAIL rnd%0d_slt got %b want %b", f, obs_slt[0], exp_slt); end
            if (obs_lat !== 2) begin errors++; $display("FAIL rnd%0d_latency got %0d want 2", f, obs_lat); end
            for (int j = 0; j < FL + 2; j++) begin
                checks++;
                if (obs_prev[j] !== exp_prev(j)) begin errors++; $display("FAIL rnd%0d_prev[%0d] got %h want %h", f, j, obs_prev[j], exp_prev(j)); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_code = 2'b00;
        i_trbk_done = 1'b0;
        test_reset();
        test_zero_frame();
        test_codeword();
        test_flip();
        test_gaps();
        test_reset_mid();
        test_done_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/viterbi_acs.md
Name: viterbi_acs

Overview:
Add-compare-select and survivor-storage stage of the rate-1/2, K=3 (generators 7/5 octal) Viterbi decoder. It sits directly upstream of the traceback stage.
- Accepts one received 2-bit hard-decision symbol per handshake and updates 4 path metrics.
- Stores one survivor decision column per symbol.
- At end of frame, selects the best end node, then replays survivor columns newest-to-oldest on the traceback's per-state previous-state inputs while holding en_trbk high.

Parameters:
FRAME_LEN, 8, symbols per frame (traceback emits FRAME_LEN decoded bits)
PM_W, 6, path-metric width in bits, saturating
PM_INIT, 15, initial metric of states 01/10/11 (state 00 starts at 0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse, begins a frame (honoured in IDLE only)
i_valid  in  1  i_code valid
i_code  in  2  received symbol {c1,c0}
o_ready  out  1  symbol accepted this cycle when i_valid&o_ready
i_trbk_done  in  1  traceback finished (traceback o_done)
o_en_trbk  out  1  drives traceback en_trbk
o_slt_node  out  2  best end state, drives traceback i_slt_node
o_prev_st_00  out  2  survivor predecessor of state 00, current replay column
o_prev_st_10  out  2  same, state 10
o_prev_st_01  out  2  same, state 01
o_prev_st_11  out  2  same, state 11
o_busy  out  1  high in every state except IDLE

Behaviour:
- State {m1,m0}, m1 = newest bit. For input bit u: next = {u,m1}; c1 = u^m1^m0; c0 = u^m0.
- Predecessors of {u,m1} are {m1,0} and {m1,1}; the decision bit is the m0 of the chosen predecessor.
- Branch metric = Hamming distance between i_code and the expected {c1,c0}, range 0..2.
- Candidate = pm[pred] + bm, saturating at 2^PM_W-1.
- Select the smaller candidate; on a tie pick the predecessor with m0=0.
- FSM states: IDLE, ACS, SEL, TRBK.
- IDLE:
  - pm00=0, pm01=pm10=pm11=PM_INIT, stage counter=0, o_ready=0.
  - i_start -> ACS on the next cycle.
- ACS:
  - o_ready=1.
  - Each accepted symbol updates all 4 metrics and writes the 4-bit decision column at address = counter, both in the same cycle; counter then increments.
  - Gaps in i_valid hold all state.
  - Acceptance of symbol FRAME_LEN-1 -> SEL; o_ready falls in the same cycle as the state change.
- SEL (1 cycle):
  - o_slt_node <= argmin of the registered metrics.
  - Ties resolve in order 00, 01, 10, 11.
  - Read pointer <= FRAME_LEN-1; -> TRBK.
- TRBK:
  - o_en_trbk=1.
  - o_prev_st_* reflect the column at the read pointer, combinationally decoded: prev = {m1, decision}, where m1 is the target state's m0.
  - Pointer decrements every cycle and saturates at 0.
  - i_trbk_done=1 -> IDLE; o_en_trbk is low from the next cycle.
  - o_slt_node is held stable throughout TRBK.
- Replay latency: the first column is valid in the first TRBK cycle; there are 2 cycles from the last symbol acceptance to o_en_trbk high.
- i_start outside IDLE is ignored; i_valid outside ACS is ignored.
- rst at any time, including mid-frame or mid-TRBK, takes effect on the next edge and forces IDLE.
- Reset values: o_en_trbk=0, o_ready=0, o_busy=0, o_slt_node=00, o_prev_st_*=00, metrics at init values, survivor memory not cleared.
- i_trbk_done while not in TRBK is ignored.

Decomposition:
- Package viterbi_pkg:
  - state constants S00/S10/S01/S11
  - generator constants G1=3'b111, G0=3'b101
  - K=3, NUM_ST=4
  - FSM state enum
  - branch-metric function
- Sub-module viterbi_surv_mem:
  - FRAME_LEN x 4 register file
  - 1 synchronous write port, 1 combinational read port
- ACS butterflies, metric registers and FSM stay in viterbi_acs.

Test Plan:
1. Reset, i_start, 8 symbols of 00 -> pm00=0, o_slt_node=00; in the first TRBK cycle o_prev_st_00=00 and o_prev_st_10=00; o_en_trbk rises exactly 2 cycles after the 8th acceptance.
2. Codeword for bits 1,0,1,1,0,0,0,0 (symbols 11,10,00,01,01,11,00,00) -> final min metric 0, o_slt_node=00; replay read pointer visits 7..0 and holds at 0.
3. Same codeword with symbol 3 flipped to 10 -> o_slt_node=00, min metric 1.
4. i_valid deasserted for 3 cycles between symbols 4 and 5 -> results identical to scenario 2; o_ready stays 1 during the gaps.
5. rst pulsed after 4 symbols, then a full new frame -> o_en_trbk=0 during reset; the new frame decodes as a clean frame.
6. i_trbk_done pulsed in TRBK -> o_en_trbk low next cycle, o_busy=0; a following i_start is accepted.
